// File: rtl/sn76489_pkg.sv
// Shared definitions for the SN76489 write path: register codes, bus sequencer
// states and the tone-latch classifier that drives the bus lock.
package sn76489_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] REG_FREQ1 = 3'b000;
    localparam logic [2:0] REG_FREQ2 = 3'b010;
    localparam logic [2:0] REG_FREQ3 = 3'b001;
    localparam logic [2:0] REG_ATT1  = 3'b100;
    localparam logic [2:0] REG_ATT2  = 3'b110;
    localparam logic [2:0] REG_ATT3  = 3'b101;
    localparam logic [2:0] REG_ATTN  = 3'b111;
    localparam logic [2:0] REG_NOISE = 3'b011;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_SETUP   = 2'd1,
        SEQ_STROBE  = 2'd2,
        SEQ_RELEASE = 2'd3
    } seq_state_t;

    // A tone-frequency latch byte must be followed by its data byte with no
    // other writer in between, otherwise the chip pairs the wrong halves.
    function automatic logic is_tone_latch(input logic [DATA_W-1:0] b);
        return b[7] && !b[4] && (b[6:5] != 2'b11);
    endfunction

endpackage

// File: rtl/sn76489_bus_sequencer.sv
// Drives one byte onto the PSG bus: SETUP, STROBE until ready (or timeout),
// RELEASE. done/timed_out are high for the single RELEASE cycle.
module sn76489_bus_sequencer
    import sn76489_pkg::*;
#(
    parameter int READY_TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              ready,
    output logic              idle,
    output logic              done,
    output logic              timed_out,
    output logic [DATA_W-1:0] d,
    output logic              nCE,
    output logic              nWE
);

    localparam int RT_W = $clog2(READY_TIMEOUT + 1);

    seq_state_t      state;
    logic [RT_W-1:0] strobe_cnt;

    assign idle = (state == SEQ_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= SEQ_IDLE;
            d          <= '0;
            nCE        <= 1'b1;
            nWE        <= 1'b1;
            done       <= 1'b0;
            timed_out  <= 1'b0;
            strobe_cnt <= '0;
        end else begin
            done      <= 1'b0;
            timed_out <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (start) begin
                        d     <= byte_in;
                        nCE   <= 1'b0;
                        nWE   <= 1'b1;
                        state <= SEQ_SETUP;
                    end
                end
                SEQ_SETUP: begin
                    nWE        <= 1'b0;
                    strobe_cnt <= '0;
                    state      <= SEQ_STROBE;
                end
                SEQ_STROBE: begin
                    // ready may still be stale in the first strobe cycle, so it is ignored there
                    if (strobe_cnt != '0 && ready) begin
                        nCE   <= 1'b1;
                        nWE   <= 1'b1;
                        done  <= 1'b1;
                        state <= SEQ_RELEASE;
                    end else if (strobe_cnt == RT_W'(READY_TIMEOUT - 1)) begin
                        nCE       <= 1'b1;
                        nWE       <= 1'b1;
                        done      <= 1'b1;
                        timed_out <= 1'b1;
                        state     <= SEQ_RELEASE;
                    end else begin
                        strobe_cnt <= strobe_cnt + RT_W'(1);
                    end
                end
                SEQ_RELEASE: begin
                    state <= SEQ_IDLE;
                end
                default: begin
                    state <= SEQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/sn76489_write_arbiter.sv
// Two-port write arbiter for the SN76489 CPU interface: round-robin between the
// Z80 bus and the player, with a bus lock spanning tone latch/data byte pairs.
module sn76489_write_arbiter
    import sn76489_pkg::*;
#(
    parameter int LOCK_TIMEOUT  = 256,
    parameter int READY_TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    output logic [DATA_W-1:0] d,
    output logic              nCE,
    output logic              nWE,
    input  logic              ready,
    output logic              grant,
    output logic              locked,
    output logic              timeout_err
);

    localparam int LT_W = $clog2(LOCK_TIMEOUT + 1);

    logic            seq_idle;
    logic            seq_done;
    logic            seq_timeout;
    logic            start;
    logic            sel;
    logic            cand0;
    logic            cand1;
    logic            owner_req;
    logic            last_grant;
    logic [LT_W-1:0] lock_timer;

    always_comb begin
        cand0     = req0 && (!locked || !grant);
        cand1     = req1 && (!locked || grant);
        sel       = (cand0 && cand1) ? ~last_grant : cand1;
        start     = seq_idle && (cand0 || cand1);
        owner_req = grant ? req1 : req0;
    end

    sn76489_bus_sequencer #(
        .READY_TIMEOUT(READY_TIMEOUT)
    ) u_seq (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .byte_in  (sel ? data1 : data0),
        .ready    (ready),
        .idle     (seq_idle),
        .done     (seq_done),
        .timed_out(seq_timeout),
        .d        (d),
        .nCE      (nCE),
        .nWE      (nWE)
    );

    assign ack0 = seq_done && !grant;
    assign ack1 = seq_done && grant;

    always_ff @(posedge clock) begin
        if (reset) begin
            grant       <= 1'b0;
            locked      <= 1'b0;
            timeout_err <= 1'b0;
            last_grant  <= 1'b1;
            lock_timer  <= '0;
        end else begin
            if (start) begin
                grant      <= sel;
                lock_timer <= '0;
            end else if (seq_idle && locked && !owner_req) begin
                // an owner that never sends its data byte must not starve the other port
                if (lock_timer == LT_W'(LOCK_TIMEOUT - 1)) begin
                    locked     <= 1'b0;
                    lock_timer <= '0;
                end else begin
                    lock_timer <= lock_timer + LT_W'(1);
                end
            end
            if (seq_done) begin
                locked     <= is_tone_latch(d);
                last_grant <= grant;
                lock_timer <= '0;
                if (seq_timeout) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sn76489_write_arbiter.sv
// Bench for sn76489_write_arbiter: queue-driven requesters, a PSG ready emulation,
// a transaction-level reference model compared every cycle, and directed checks.
module tb_sn76489_write_arbiter;

    localparam int LOCK_TO  = 16;
    localparam int READY_TO = 64;

    logic       clock;
    logic       reset;
    logic       req0, req1, ack0, ack1;
    logic [7:0] data0, data1, d;
    logic       nCE, nWE, ready, grant, locked, timeout_err;

    sn76489_write_arbiter #(.LOCK_TIMEOUT(LOCK_TO), .READY_TIMEOUT(READY_TO)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .d(d), .nCE(nCE), .nWE(nWE), .ready(ready),
        .grant(grant), .locked(locked), .timeout_err(timeout_err)
    );

    typedef struct {
        int         port;
        logic [7:0] b;
        int         cyc;
        logic       lk;
    } ent_t;

    ent_t       log_q[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int cyc = 0;
    int r_cyc0 = 0;
    int r_cyc1 = 0;
    int nce_low = 0;
    int nwe_low = 0;
    int ready_wait = 1;
    int wcnt = 0;
    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    int         m_age, m_quiet;
    logic       m_rel, m_to, m_grant, m_locked, m_terr, m_last, m_valid;
    logic [7:0] m_byte;
    logic       w0, w1;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 300000", $time);
        $fatal(1);
    end

    // requester port 0: holds req until ack, then moves on to its next queued byte
    initial begin
        req0 = 0;
        data0 = 0;
        forever begin
            @(negedge clock);
            if (req0 && ack0) begin
                if (q0.size() > 0) void'(q0.pop_front());
                if (q0.size() > 0) data0 = q0[0];
                else req0 = 0;
            end else if (req0 && q0.size() == 0) begin
                req0 = 0;
            end else if (!req0 && q0.size() > 0) begin
                req0 = 1;
                data0 = q0[0];
                r_cyc0 = cyc;
            end
        end
    end

    initial begin
        req1 = 0;
        data1 = 0;
        forever begin
            @(negedge clock);
            if (req1 && ack1) begin
                if (q1.size() > 0) void'(q1.pop_front());
                if (q1.size() > 0) data1 = q1[0];
                else req1 = 0;
            end else if (req1 && q1.size() == 0) begin
                req1 = 0;
            end else if (!req1 && q1.size() > 0) begin
                req1 = 1;
                data1 = q1[0];
                r_cyc1 = cyc;
            end
        end
    end

    // PSG emulation: ready drops while nWE is low and returns after ready_wait strobe cycles
    initial begin
        ready = 1;
        forever begin
            @(negedge clock);
            if (nWE !== 1'b0) wcnt = 0;
            else wcnt++;
            ready = (nWE !== 1'b0) || (wcnt >= ready_wait);
        end
    end

    initial forever begin
        ent_t e;
        @(negedge clock);
        if (ack0 === 1'b1) begin
            e.port = 0; e.b = d; e.cyc = cyc; e.lk = locked;
            log_q.push_back(e);
        end
        if (ack1 === 1'b1) begin
            e.port = 1; e.b = d; e.cyc = cyc; e.lk = locked;
            log_q.push_back(e);
        end
        if (nCE === 1'b0) nce_low++;
        if (nWE === 1'b0) nwe_low++;
    end

    function automatic logic tone_latch(input logic [7:0] b);
        return (b[7] == 1'b1) && (b[4] == 1'b0) && (b[6:5] != 2'b11);
    endfunction

    // Transfer model: m_age counts cycles into a transfer (1 = setup, k+1 = k-th strobe cycle)
    initial begin
        m_valid = 0;
        forever begin
            @(posedge clock);
            if (reset) begin
                m_age = 0; m_rel = 0; m_to = 0; m_byte = 0; m_grant = 0;
                m_locked = 0; m_terr = 0; m_last = 1; m_quiet = 0;
            end else if (m_rel) begin
                m_rel = 0;
                m_age = 0;
                m_last = m_grant;
                m_locked = tone_latch(m_byte);
                m_quiet = 0;
                if (m_to) m_terr = 1;
            end else if (m_age == 0) begin
                w0 = req0 && !(m_locked && m_grant);
                w1 = req1 && !(m_locked && !m_grant);
                if (w0 || w1) begin
                    m_grant = (w0 && w1) ? !m_last : w1;
                    m_byte = m_grant ? data1 : data0;
                    m_age = 1;
                    m_quiet = 0;
                end else if (m_locked) begin
                    m_quiet++;
                    if (m_quiet == LOCK_TO) begin
                        m_locked = 0;
                        m_quiet = 0;
                    end
                end
            end else if (m_age >= 3 && ready) begin
                m_rel = 1;
                m_to = 0;
            end else if (m_age - 1 == READY_TO) begin
                m_rel = 1;
                m_to = 1;
            end else begin
                m_age++;
            end
            m_valid = 1;
        end
    end

    initial forever begin
        logic [14:0] act, exp;
        @(negedge clock);
        if (m_valid) begin
            exp = {m_byte, !(m_age >= 1 && !m_rel), !(m_age >= 2 && !m_rel),
                   m_rel && !m_grant, m_rel && m_grant, m_grant, m_locked, m_terr};
            act = {d, nCE, nWE, ack0, ack1, grant, locked, timeout_err};
            n_cmp++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL cycle_model cyc=%0d: dut {d,nCE,nWE,ack0,ack1,grant,locked,terr}=%b model=%b",
                         cyc, act, exp);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic wait_acks(input int n, input int budget, input string nm);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            @(posedge clock);
            #2;
            k++;
        end
        chk(nm, log_q.size() >= n, 1);
    endtask

    function automatic ent_t entry(input int i);
        ent_t e;
        e.port = -1; e.b = 8'h00; e.cyc = -1000; e.lk = 1'bx;
        if (i < log_q.size()) e = log_q[i];
        return e;
    endfunction

    initial begin
        ent_t e, e2;
        reset = 1;
        repeat (3) @(posedge clock);
        #2 reset = 0;

        // reset state
        chk("rst_d", d, 0);
        chk("rst_nCE", nCE, 1);
        chk("rst_nWE", nWE, 1);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_grant", grant, 0);
        chk("rst_locked", locked, 0);
        chk("rst_terr", timeout_err, 0);

        // single write, ready returns after 32 strobe cycles
        idle(1);
        ready_wait = 32; nce_low = 0; nwe_low = 0; log_q.delete();
        q0.push_back(8'h9A);
        wait_acks(1, 200, "single_ack_seen");
        idle(4);
        e = entry(0);
        chk("single_port", e.port, 0);
        chk("single_byte", e.b, 8'h9A);
        chk("single_latency", e.cyc - r_cyc0, 34);
        chk("single_ack_count", log_q.size(), 1);
        chk("single_nce_cycles", nce_low, 33);
        chk("single_nwe_cycles", nwe_low, 32);
        chk("single_locked", locked, 0);

        // tie from reset: port 0, port 1, port 0, port 1
        reset = 1; ready_wait = 1;
        q0.push_back(8'h11); q0.push_back(8'h12);
        q1.push_back(8'h21); q1.push_back(8'h22);
        idle(2);
        reset = 0; log_q.delete();
        wait_acks(4, 100, "tie_acks_seen");
        idle(3);
        e = entry(0); chk("tie0_port", e.port, 0); chk("tie0_byte", e.b, 8'h11);
        e2 = entry(1); chk("tie1_port", e2.port, 1); chk("tie1_byte", e2.b, 8'h21);
        chk("tie_spacing", e2.cyc - e.cyc, 5);
        e = entry(2); chk("tie2_port", e.port, 0); chk("tie2_byte", e.b, 8'h12);
        e = entry(3); chk("tie3_port", e.port, 1); chk("tie3_byte", e.b, 8'h22);

        // lock: port 1 latch+data pair is not interleaved by pending port 0
        log_q.delete();
        q1.push_back(8'hA5); q1.push_back(8'h3E);
        idle(3);
        q0.push_back(8'h44);
        wait_acks(3, 100, "lock_acks_seen");
        idle(3);
        e = entry(0); chk("lock0_port", e.port, 1); chk("lock0_byte", e.b, 8'hA5); chk("lock0_lk", e.lk, 0);
        e = entry(1); chk("lock1_port", e.port, 1); chk("lock1_byte", e.b, 8'h3E); chk("lock1_lk", e.lk, 1);
        e = entry(2); chk("lock2_port", e.port, 0); chk("lock2_byte", e.b, 8'h44); chk("lock2_lk", e.lk, 0);
        chk("lock_cleared", locked, 0);

        // lock timeout: owner goes quiet after a latch, other port waits 16 idle cycles
        log_q.delete();
        q0.push_back(8'h81);
        idle(2);
        q1.push_back(8'h55);
        wait_acks(1, 100, "lto_first_ack_seen");
        idle(5);
        chk("lto_locked_held", locked, 1);
        chk("lto_owner", grant, 0);
        wait_acks(2, 100, "lto_second_ack_seen");
        idle(3);
        e = entry(0); chk("lto0_byte", e.b, 8'h81);
        e2 = entry(1); chk("lto1_port", e2.port, 1); chk("lto1_byte", e2.b, 8'h55);
        chk("lto_gap", e2.cyc - e.cyc, 21);
        chk("lto1_lk", e2.lk, 0);

        // attenuation and noise bytes never lock: ports alternate
        log_q.delete();
        q0.push_back(8'hBA); q0.push_back(8'hE5);
        q1.push_back(8'h66); q1.push_back(8'h67);
        wait_acks(4, 100, "nolock_acks_seen");
        idle(3);
        e = entry(0); chk("nl0_port", e.port, 0); chk("nl0_byte", e.b, 8'hBA);
        e = entry(1); chk("nl1_port", e.port, 1); chk("nl1_lk", e.lk, 0);
        e = entry(2); chk("nl2_port", e.port, 0); chk("nl2_byte", e.b, 8'hE5);
        e = entry(3); chk("nl3_port", e.port, 1); chk("nl3_lk", e.lk, 0);
        chk("nl_locked", locked, 0);

        // ready stuck low: forced release after 64 strobe cycles, sticky error
        log_q.delete(); ready_wait = 1000;
        q0.push_back(8'h12);
        wait_acks(1, 200, "rto_ack_seen");
        e = entry(0);
        chk("rto_port", e.port, 0);
        chk("rto_latency", e.cyc - r_cyc0, 66);
        chk("rto_terr_set", timeout_err, 1);
        log_q.delete(); ready_wait = 1;
        q1.push_back(8'h13);
        wait_acks(1, 50, "rto_next_ack_seen");
        idle(2);
        chk("rto_next_port", entry(0).port, 1);
        chk("rto_terr_sticky", timeout_err, 1);

        // reset in the middle of a strobe
        log_q.delete(); ready_wait = 1000;
        q0.push_back(8'h14);
        idle(6);
        chk("mid_in_strobe_nWE", nWE, 0);
        reset = 1;
        q0.delete();
        idle(1);
        chk("mid_rst_nCE", nCE, 1);
        chk("mid_rst_nWE", nWE, 1);
        chk("mid_rst_terr", timeout_err, 0);
        chk("mid_rst_d", d, 0);
        reset = 0; ready_wait = 1;
        idle(5);
        chk("mid_rst_no_ack", log_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
